hall_pattern_gen: RTL

- Emulates a 3-channel 120-degree Hall sensor, the transmit side of the Hall speed-measurement path.
- Steps through the six-state Hall sequence at a programmable rate and direction.
- Drives a bench motor-less loop and acts as a self-test source for the Hall encoder/speed counter.
- Also reports the current sector, a per-step strobe and a wrapping step count.

---
 rtl/hall_pkg.sv | 48 ++++
 rtl/hall_step_timer.sv | 36 +++
 rtl/hall_pattern_gen.sv | 85 ++++++++
 3 files changed

// File: rtl/hall_pkg.sv
// Shared Hall-sequence definitions: sector encoding, code table and step helpers.
package hall_pkg;

  localparam int unsigned SECTOR_W = 3;
  localparam int unsigned HALL_W   = 3;

  typedef enum logic [SECTOR_W-1:0] {
    SEC0 = 3'd0,
    SEC1 = 3'd1,
    SEC2 = 3'd2,
    SEC3 = 3'd3,
    SEC4 = 3'd4,
    SEC5 = 3'd5
  } sector_t;

  // Forward order {C,B,A}; each neighbour differs in exactly one bit.
  localparam logic [HALL_W-1:0] HALL_SEQ [0:5] = '{
    3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
  };

  localparam logic [HALL_W-1:0] HALL_INVALID_000 = 3'b000;
  localparam logic [HALL_W-1:0] HALL_INVALID_111 = 3'b111;

  function automatic logic [HALL_W-1:0] hall_lookup(input sector_t s);
    case (s)
      SEC0:    return HALL_SEQ[0];
      SEC1:    return HALL_SEQ[1];
      SEC2:    return HALL_SEQ[2];
      SEC3:    return HALL_SEQ[3];
      SEC4:    return HALL_SEQ[4];
      SEC5:    return HALL_SEQ[5];
      default: return HALL_INVALID_111;
    endcase
  endfunction

  function automatic sector_t sector_step(input sector_t s, input logic fwd);
    case (s)
      SEC0:    return fwd ? SEC1 : SEC5;
      SEC1:    return fwd ? SEC2 : SEC0;
      SEC2:    return fwd ? SEC3 : SEC1;
      SEC3:    return fwd ? SEC4 : SEC2;
      SEC4:    return fwd ? SEC5 : SEC3;
      SEC5:    return fwd ? SEC0 : SEC4;
      default: return SEC0;
    endcase
  endfunction

endpackage

// File: rtl/hall_step_timer.sv
// Step-period down-counter: clamps and latches the period at each boundary and
// emits a single-cycle tick (combinational) on the cycle the step is taken.
module hall_step_timer #(
  parameter int unsigned PER_W   = 16,
  parameter int unsigned MIN_PER = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [PER_W-1:0] i_period,
  output logic             o_tick_c
);

  localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PER);

  logic [PER_W-1:0] r_timer;
  logic             r_load_pend;
  logic [PER_W-1:0] w_per_clamp;

  assign w_per_clamp = (i_period < MIN_P) ? MIN_P : i_period;
  assign o_tick_c    = i_en & ~r_load_pend & (r_timer == '0);

  // The timer holds (latched period - 1); reloading it is the period latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer     <= MIN_P - PER_W'(1);
      r_load_pend <= 1'b1;
    end else if (r_load_pend || o_tick_c) begin
      r_timer     <= w_per_clamp - PER_W'(1);
      r_load_pend <= 1'b0;
    end else if (i_en) begin
      r_timer     <= r_timer - PER_W'(1);
    end
  end

endmodule

// File: rtl/hall_pattern_gen.sv
// Three-channel 120-degree Hall sensor emulator with sector, step strobe and step count.
// Optional HALL_FAULT_INJ_EN adds fault_inj, forcing H to the open-sensor code 000.
module hall_pattern_gen
  import hall_pkg::*;
#(
  parameter int unsigned PER_W   = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MIN_PER = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic                dir,
  input  logic [PER_W-1:0]    period,
  input  logic                cnt_clr,
`ifdef HALL_FAULT_INJ_EN
  input  logic                fault_inj,
`endif
  output logic [HALL_W-1:0]   H,
  output logic [SECTOR_W-1:0] sector,
  output logic                step_stb,
  output logic [CNT_W-1:0]    step_cnt
);

  logic                w_tick;
  sector_t             r_sector;
  sector_t             w_sector_nxt;
  logic [HALL_W-1:0]   r_h;
  logic [HALL_W-1:0]   w_h_nxt;
  logic                r_stb;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  hall_step_timer #(
    .PER_W   (PER_W),
    .MIN_PER (MIN_PER)
  ) u_timer (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_en     (en),
    .i_period (period),
    .o_tick_c (w_tick)
  );

  // Sector FSM next state; H is looked up from the next sector so all outputs move together.
  always_comb begin
    w_sector_nxt = r_sector;
    w_cnt_nxt    = r_cnt;
    w_h_nxt      = HALL_INVALID_000;
    if (w_tick) begin
      w_sector_nxt = sector_step(r_sector, dir);
      w_cnt_nxt    = r_cnt + CNT_W'(1);
    end
    if (cnt_clr) begin
      w_cnt_nxt = '0;
    end
`ifdef HALL_FAULT_INJ_EN
    if (!fault_inj) begin
      w_h_nxt = hall_lookup(w_sector_nxt);
    end
`else
    w_h_nxt = hall_lookup(w_sector_nxt);
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sector <= SEC0;
      r_h      <= HALL_SEQ[0];
      r_stb    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sector <= w_sector_nxt;
      r_h      <= w_h_nxt;
      r_stb    <= w_tick;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign H        = r_h;
  assign sector   = r_sector;
  assign step_stb = r_stb;
  assign step_cnt = r_cnt;

endmodule
